// File: rtl/cpu_fetch.sv
// -----------------------------------------------------------------------------
// cpu_fetch
//
// Instruction fetch stage. Owns the program counter, issues word requests to
// instruction memory, collects the in-order responses into a small queue and
// hands them to the decoder through a valid/ready handshake. A branch redirect
// from execute flushes the queue, moves the PC and arranges for every response
// still in flight to be thrown away when it returns.
//
// Parameters
//   DEPTH     queue entries; also the cap on (requests in flight + words queued)
//   RESET_PC  first fetch address (word aligned)
//
// Ports
//   clk, reset                       clock, async active-high reset
//   imem_req_valid/ready, imem_addr  request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data    response channel (always accepted)
//   branch_valid, branch_target      redirect from execute
//   instr_valid/ready, instr_out,
//   instr_pc                         instruction handshake to the decoder
// -----------------------------------------------------------------------------
module cpu_fetch #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // one spare bit so outstanding + count never wraps before the compare
    localparam int unsigned CW = $clog2(DEPTH + 1) + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc;
    logic [31:0] rsp_pc;
    cnt_t        outstanding;
    cnt_t        drop_cnt;
    cnt_t        count;
    ptr_t        head;
    ptr_t        tail;
    logic [31:0] q_data [DEPTH];
    logic [31:0] q_pc   [DEPTH];

    logic        pop;
    logic        push;
    logic        req_fire;
    cnt_t        credit_used;
    cnt_t        outstanding_nxt;
    logic [31:0] target_aligned;
    logic        unused_target_bits;

    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_inc = (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign target_aligned     = {branch_target[31:2], 2'b00};
    assign unused_target_bits = ^branch_target[1:0];

    // A redirect hides the head in the same cycle so the decoder never
    // consumes a word from the path being abandoned.
    assign instr_valid = (count != '0) && !branch_valid;
    assign pop         = instr_valid && instr_ready;

    // Credit rule: a slot freed by this cycle's pop may be reused immediately,
    // which is what keeps one-per-cycle throughput with DEPTH=2 and L=1.
    assign credit_used    = outstanding + count - cnt_t'(pop);
    assign imem_req_valid = !reset && (credit_used < cnt_t'(DEPTH));
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push = imem_rsp_valid && !branch_valid && (drop_cnt == '0);

    assign outstanding_nxt = outstanding + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid);

    assign instr_out = q_data[head];
    assign instr_pc  = q_pc[head];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC_ALIGNED;
            rsp_pc      <= RESET_PC_ALIGNED;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else begin
            outstanding <= outstanding_nxt;
            if (req_fire) begin
                pc <= pc + 32'd4;
            end

            if (branch_valid) begin
                // Everything still in flight after this edge, including a
                // request accepted this cycle at the old pc, is stale.
                pc       <= target_aligned;
                rsp_pc   <= target_aligned;
                drop_cnt <= outstanding_nxt;
                count    <= '0;
                head     <= '0;
                tail     <= '0;
            end else begin
                if (imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - cnt_t'(1);
                end
                if (push) begin
                    q_data[tail] <= imem_rsp_data;
                    q_pc[tail]   <= rsp_pc;
                    tail         <= ptr_inc(tail);
                    rsp_pc       <= rsp_pc + 32'd4;
                end
                if (pop) begin
                    head <= ptr_inc(head);
                end
                count <= count + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end

endmodule

// File: tb/tb_cpu_fetch.sv
module tb_cpu_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    cpu_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .branch_valid   (branch_valid),
        .branch_target  (branch_target),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // instruction memory contents as a function of address
    function automatic logic [31:0] fdata(input logic [31:0] a);
        fdata = a * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } mreq_t;

    mreq_t mem_q[$];
    int    cyc      = 0;
    bit    rdy_rand = 0;
    bit    gap_rand = 0;
    int    lat_min  = 1;
    int    lat_max  = 1;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (reset) begin
            imem_rsp_valid = 1'b0;
            imem_req_ready = 1'b1;
        end else begin
            imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (mem_q.size() != 0 && mem_q[0].due <= cyc &&
                (!gap_rand || $urandom_range(0, 2) != 0)) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = fdata(mem_q[0].addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    // ---------------- behavioural fetch model + compare ----------------
    logic [31:0] exp_q[$];      // PCs of kept words not yet handed to decoder
    logic [31:0] req_pc;        // next address the fetch stage should ask for
    int          epoch     = 0;
    bit          have_last = 0;
    logic [31:0] last_pc;
    int          n_pop     = 0;

    always @(negedge clk) begin
        bit          exp_valid;
        bit          pop_e;
        bit          exp_req;
        logic [31:0] p;
        mreq_t       e;
        if (reset) begin
            mem_q.delete();
            exp_q.delete();
            req_pc    = RESET_PC;
            epoch     = 0;
            have_last = 0;
            chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
            chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
            chk("rst_imem_addr", imem_addr, RESET_PC);
            chk("rst_instr_out", instr_out, 32'd0);
            chk("rst_instr_pc", instr_pc, 32'd0);
        end else begin
            exp_valid = (exp_q.size() != 0) && !branch_valid;
            pop_e     = exp_valid && instr_ready;
            exp_req   = (mem_q.size() + exp_q.size() - int'(pop_e)) < DEPTH;
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
            if (exp_valid) begin
                chk("instr_pc", instr_pc, exp_q[0]);
                chk("instr_out", instr_out, fdata(exp_q[0]));
            end
            chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
            if (exp_req) chk("imem_addr", imem_addr, req_pc);
            chk("credit_bound", {31'd0, (mem_q.size() + exp_q.size()) <= DEPTH}, 32'd1);

            if (pop_e) begin
                p = exp_q.pop_front();
                n_pop++;
                if (have_last) chk("pc_step", instr_pc, last_pc + 32'd4);
                last_pc   = instr_pc;
                have_last = 1;
            end
            if (imem_rsp_valid && mem_q.size() != 0) begin
                e = mem_q.pop_front();
                if (!branch_valid && e.ep == epoch) exp_q.push_back(e.addr);
            end
            if (imem_req_valid && imem_req_ready) begin
                e.addr = imem_addr;
                e.due  = cyc + $urandom_range(lat_min, lat_max);
                e.ep   = epoch;
                mem_q.push_back(e);
                req_pc = req_pc + 32'd4;
            end
            if (branch_valid) begin
                exp_q.delete();
                epoch++;
                req_pc    = {branch_target[31:2], 2'b00};
                have_last = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!instr_valid && n < 40) begin
            tick();
            n++;
        end
        chk(nm, {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic do_reset();
        drive();
        reset = 1'b1;
        drive();
        drive();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nfire;
        reset          = 1'b1;
        branch_valid   = 1'b0;
        branch_target  = 32'd0;
        instr_ready    = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        repeat (3) drive();

        // streaming after reset release, L=1
        reset = 1'b0;
        tick();
        chk("t1_req0_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("t1_req0_addr", imem_addr, 32'h0);
        chk("t1_valid_c0", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("t1_req1_addr", imem_addr, 32'h4);
        chk("t1_valid_c1", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("t1_first_valid", {31'd0, instr_valid}, 32'd1);
        chk("t1_first_pc", instr_pc, 32'h0);
        chk("t1_first_data", instr_out, fdata(32'h0));
        tick();
        chk("t1_second_pc", instr_pc, 32'h4);
        chk("t1_req3_addr", imem_addr, 32'hC);
        tick();
        chk("t1_third_pc", instr_pc, 32'h8);
        chk("t1_third_valid", {31'd0, instr_valid}, 32'd1);

        // decoder stall
        instr_ready = 1'b0;
        do_reset();
        nfire = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (imem_req_valid && imem_req_ready) nfire++;
        end
        chk("t2_req_count", nfire, 32'd2);
        chk("t2_stall_valid", {31'd0, instr_valid}, 32'd1);
        chk("t2_stall_pc", instr_pc, 32'h0);
        drive();
        instr_ready = 1'b1;
        tick();
        chk("t2_rel_pc0", instr_pc, 32'h0);
        tick();
        chk("t2_rel_pc1", instr_pc, 32'h4);
        chk("t2_rel_data1", instr_out, fdata(32'h4));

        // redirect with two requests in flight, L=3
        lat_min = 3;
        lat_max = 3;
        do_reset();
        drive();
        drive();
        branch_valid  = 1'b1;
        branch_target = 32'h200;
        tick();
        chk("t3_br_hides_valid", {31'd0, instr_valid}, 32'd0);
        drive();
        branch_valid = 1'b0;
        tick();
        chk("t3_addr_after_br", imem_addr, 32'h200);
        wait_valid("t3_wait_valid");
        chk("t3_first_pc", instr_pc, 32'h200);
        chk("t3_first_data", instr_out, fdata(32'h200));

        // unaligned target, L=1
        lat_min = 1;
        lat_max = 1;
        repeat (4) drive();
        branch_valid  = 1'b1;
        branch_target = 32'h103;
        drive();
        branch_valid = 1'b0;
        tick();
        chk("t4_addr_aligned", imem_addr, 32'h100);
        wait_valid("t4_wait_valid");
        chk("t4_first_pc", instr_pc, 32'h100);
        chk("t4_first_data", instr_out, fdata(32'h100));

        // random traffic
        rdy_rand = 1;
        gap_rand = 1;
        lat_min  = 1;
        lat_max  = 3;
        n_pop    = 0;
        for (int i = 0; i < 1000; i++) begin
            drive();
            instr_ready   = ($urandom_range(0, 1) != 0);
            branch_valid  = ($urandom_range(0, 49) == 0);
            branch_target = $urandom & 32'h0000_FFFF;
        end
        drive();
        branch_valid = 1'b0;
        instr_ready  = 1'b1;
        repeat (10) drive();
        chk("t5_progress", {31'd0, n_pop > 100}, 32'd1);

        // reset with queued word and a request in flight
        rdy_rand    = 0;
        gap_rand    = 0;
        lat_min     = 3;
        lat_max     = 3;
        instr_ready = 1'b0;
        repeat (6) drive();
        chk("t6_pre_valid", {31'd0, instr_valid}, 32'd1);
        reset = 1'b1;
        tick();
        chk("t6_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("t6_rst_req", {31'd0, imem_req_valid}, 32'd0);
        chk("t6_rst_out", instr_out, 32'd0);
        chk("t6_rst_pc", instr_pc, 32'd0);
        chk("t6_rst_addr", imem_addr, RESET_PC);
        drive();
        reset       = 1'b0;
        instr_ready = 1'b1;
        tick();
        chk("t6_first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("t6_first_req_addr", imem_addr, RESET_PC);
        wait_valid("t6_wait_valid");
        chk("t6_first_pc", instr_pc, RESET_PC);
        repeat (10) drive();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
